// File: rtl/instr_fetch_if.sv
// Fetch-stage bundle: run control, branch resolution, target-table writes,
// instruction-memory port and decoder-facing outputs.
interface instr_fetch_if #(
    parameter int PC_W = 10
);
    logic            start;
    logic            stall;
    logic            br_taken;
    logic [3:0]      br_idx;
    logic            lut_we;
    logic [3:0]      lut_idx;
    logic [PC_W-1:0] lut_wdata;
    logic [PC_W-1:0] imem_addr;
    logic [8:0]      imem_rdata;
    logic [8:0]      instr;
    logic            instr_valid;
    logic [PC_W-1:0] pc;
    logic            done;
    logic [15:0]     br_count;

    modport master (
        input  start, stall, br_taken, br_idx, lut_we, lut_idx, lut_wdata, imem_rdata,
        output imem_addr, instr, instr_valid, pc, done, br_count
    );

    modport slave (
        output start, stall, br_taken, br_idx, lut_we, lut_idx, lut_wdata, imem_rdata,
        input  imem_addr, instr, instr_valid, pc, done, br_count
    );
endinterface

// File: rtl/instr_fetch.sv
// Instruction fetch stage: PC, 16-entry jump-target table, IDLE/RUN/HALT control.
// Optional taken-branch counter enabled with `define INSTR_FETCH_BR_COUNT_EN.
module instr_fetch #(
    parameter int              PC_W     = 10,
    parameter logic [PC_W-1:0] RESET_PC = '0,
    parameter logic [8:0]      HALT_OP  = 9'h1FF
) (
    input logic           clk,
    input logic           rst_n,
    instr_fetch_if.master bus
);
    // state  | meaning
    // S_IDLE | waiting for start, pc held, no valid instruction
    // S_RUN  | fetching one word per unstalled cycle
    // S_HALT | halt word retired, pc frozen, done asserted
    typedef enum logic [1:0] {S_IDLE, S_RUN, S_HALT} state_t;

    state_t          state;
    logic [PC_W-1:0] pc_q;
    logic [8:0]      instr_q;
    logic            valid_q;
    logic            done_q;
    logic [PC_W-1:0] lut [16];

    assign bus.imem_addr   = pc_q;
    assign bus.pc          = pc_q;
    assign bus.instr       = instr_q;
    assign bus.instr_valid = valid_q;
    assign bus.done        = done_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state   <= S_IDLE;
            pc_q    <= RESET_PC;
            instr_q <= '0;
            valid_q <= 1'b0;
            done_q  <= 1'b0;
            for (int i = 0; i < 16; i++) lut[i] <= '0;
        end else begin
            if (bus.lut_we) lut[bus.lut_idx] <= bus.lut_wdata;

            if (bus.start) begin
                state   <= S_RUN;
                pc_q    <= RESET_PC;
                valid_q <= 1'b0;
                done_q  <= 1'b0;
            end else begin
                case (state)
                    S_IDLE: valid_q <= 1'b0;
                    S_RUN: begin
                        if (!bus.stall) begin
                            instr_q <= bus.imem_rdata;
                            // taken branch: the word captured now is the wrong-path fall-through
                            if (bus.br_taken) begin
                                pc_q    <= lut[bus.br_idx];
                                valid_q <= 1'b0;
                            end else begin
                                pc_q    <= pc_q + 1'b1;
                                valid_q <= 1'b1;
                                if (bus.imem_rdata == HALT_OP) state <= S_HALT;
                            end
                        end
                    end
                    S_HALT: begin
                        valid_q <= 1'b0;
                        done_q  <= 1'b1;
                    end
                    default: state <= S_IDLE;
                endcase
            end
        end
    end

`ifdef INSTR_FETCH_BR_COUNT_EN
    logic [15:0] br_cnt_q;

    always_ff @(posedge clk) begin
        if (!rst_n || bus.start) begin
            br_cnt_q <= '0;
        end else if (state == S_RUN && !bus.stall && bus.br_taken && br_cnt_q != 16'hFFFF) begin
            br_cnt_q <= br_cnt_q + 16'd1;
        end
    end

    assign bus.br_count = br_cnt_q;
`else
    assign bus.br_count = '0;
`endif

endmodule

// File: tb/tb_instr_fetch.sv
// Directed bench for instr_fetch: fetch order, branch squash, stall, halt,
// PC wrap, reset mid-run and target-table read-before-write.
module tb_instr_fetch;
    logic clk = 1'b0;
    logic rst_n;
    int   n_checks = 0;
    int   n_errors = 0;
    logic [8:0] mem [1024];

    always #5 clk = ~clk;

    instr_fetch_if #(.PC_W(10)) bus ();

    instr_fetch #(.PC_W(10), .RESET_PC(10'h000), .HALT_OP(9'h1FF)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    assign bus.imem_rdata = mem[bus.imem_addr];

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic expect_fetch(input string tag, input logic [8:0] e_instr, input logic e_valid,
                                input logic [9:0] e_pc, input logic e_done);
        check_eq({tag, ".instr"}, 32'(bus.instr), 32'(e_instr));
        check_eq({tag, ".valid"}, 32'(bus.instr_valid), 32'(e_valid));
        check_eq({tag, ".pc"}, 32'(bus.pc), 32'(e_pc));
        check_eq({tag, ".done"}, 32'(bus.done), 32'(e_done));
    endtask

    function automatic logic [15:0] exp_cnt(input int n);
`ifdef INSTR_FETCH_BR_COUNT_EN
        return 16'(n);
`else
        return 16'(n * 0);
`endif
    endfunction

    initial begin
        for (int i = 0; i < 1024; i++) mem[i] = 9'h000;
        mem[0] = 9'h010; mem[1] = 9'h011; mem[2] = 9'h012; mem[3] = 9'h013;
        mem[4] = 9'h1FF;
        mem[10'h040] = 9'h055; mem[10'h041] = 9'h056;
        mem[10'h3FE] = 9'h0AA; mem[10'h3FF] = 9'h0BB;

        rst_n = 1'b0; bus.start = 0; bus.stall = 0; bus.br_taken = 0; bus.br_idx = 0;
        bus.lut_we = 0; bus.lut_idx = 0; bus.lut_wdata = 0;
        #2;
        step(); step();
        expect_fetch("reset", 9'h000, 1'b0, 10'h000, 1'b0);
        check_eq("reset.addr", 32'(bus.imem_addr), 32'h0);
        check_eq("reset.brcnt", 32'(bus.br_count), 32'h0);

        rst_n = 1'b1;
        bus.lut_we = 1; bus.lut_idx = 4'd5; bus.lut_wdata = 10'h040;
        step();
        bus.lut_we = 0;
        step();
        expect_fetch("idle", 9'h000, 1'b0, 10'h000, 1'b0);

        bus.start = 1; step(); bus.start = 0;
        expect_fetch("start", 9'h000, 1'b0, 10'h000, 1'b0);
        step(); expect_fetch("f0", 9'h010, 1'b1, 10'h001, 1'b0);
        check_eq("f0.addr", 32'(bus.imem_addr), 32'h001);
        step(); expect_fetch("f1", 9'h011, 1'b1, 10'h002, 1'b0);
        step(); expect_fetch("f2", 9'h012, 1'b1, 10'h003, 1'b0);

        bus.br_taken = 1; bus.br_idx = 4'd5;
        step();
        bus.br_taken = 0;
        expect_fetch("br_bubble", 9'h013, 1'b0, 10'h040, 1'b0);
        step(); expect_fetch("br_tgt", 9'h055, 1'b1, 10'h041, 1'b0);
        check_eq("br.cnt1", 32'(bus.br_count), 32'(exp_cnt(1)));

        bus.stall = 1; bus.br_taken = 1; bus.br_idx = 4'd5;
        for (int k = 0; k < 3; k++) begin
            step();
            expect_fetch($sformatf("stall%0d", k), 9'h055, 1'b1, 10'h041, 1'b0);
        end
        check_eq("stall.cnt", 32'(bus.br_count), 32'(exp_cnt(1)));
        bus.stall = 0; bus.br_taken = 0;
        step(); expect_fetch("unstall", 9'h056, 1'b1, 10'h042, 1'b0);

        bus.start = 1; step(); bus.start = 0;
        expect_fetch("restart", 9'h056, 1'b0, 10'h000, 1'b0);
        check_eq("restart.cnt", 32'(bus.br_count), 32'h0);
        step(); expect_fetch("h0", 9'h010, 1'b1, 10'h001, 1'b0);
        step(); step(); step();
        expect_fetch("h3", 9'h013, 1'b1, 10'h004, 1'b0);
        step(); expect_fetch("halt_word", 9'h1FF, 1'b1, 10'h005, 1'b0);
        bus.lut_we = 1; bus.lut_idx = 4'd6; bus.lut_wdata = 10'h3FE;
        step(); bus.lut_we = 0;
        expect_fetch("halted", 9'h1FF, 1'b0, 10'h005, 1'b0 | 1'b1);
        step(); expect_fetch("halted2", 9'h1FF, 1'b0, 10'h005, 1'b1);

        bus.start = 1; step(); bus.start = 0;
        expect_fetch("unhalt", 9'h1FF, 1'b0, 10'h000, 1'b0);
        step(); expect_fetch("u0", 9'h010, 1'b1, 10'h001, 1'b0);
        step(); step(); step();
        expect_fetch("u3", 9'h013, 1'b1, 10'h004, 1'b0);

        bus.br_taken = 1; bus.br_idx = 4'd6;
        step();
        bus.br_taken = 0;
        expect_fetch("squash_halt", 9'h1FF, 1'b0, 10'h3FE, 1'b0);
        step(); expect_fetch("w0", 9'h0AA, 1'b1, 10'h3FF, 1'b0);
        step(); expect_fetch("wrap", 9'h0BB, 1'b1, 10'h000, 1'b0);
        step(); expect_fetch("w2", 9'h010, 1'b1, 10'h001, 1'b0);
        check_eq("wrap.cnt", 32'(bus.br_count), 32'(exp_cnt(1)));

        rst_n = 1'b0; step(); rst_n = 1'b1;
        expect_fetch("rst_mid", 9'h000, 1'b0, 10'h000, 1'b0);
        check_eq("rst_mid.cnt", 32'(bus.br_count), 32'h0);

        bus.start = 1; step(); bus.start = 0;
        bus.br_taken = 1; bus.br_idx = 4'd5;
        bus.lut_we = 1; bus.lut_idx = 4'd5; bus.lut_wdata = 10'h123;
        step();
        bus.lut_we = 0;
        expect_fetch("lut_clr_rbw", 9'h010, 1'b0, 10'h000, 1'b0);
        step();
        bus.br_taken = 0;
        expect_fetch("lut_new", 9'h010, 1'b0, 10'h123, 1'b0);
        step(); expect_fetch("lut_tgt", 9'h000, 1'b1, 10'h124, 1'b0);
        check_eq("final.cnt", 32'(bus.br_count), 32'(exp_cnt(2)));

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end
endmodule

// File: doc/instr_fetch.md
Name: instr_fetch

Overview:
- Fetch stage directly upstream of the instruction decoder: owns the program counter, reads 9-bit instruction words from instruction memory and presents one registered instruction per cycle to the decoder.
- Jump targets come from a loadable 16-entry target table indexed by the 4-bit jump immediate that the decoder extracts.
- Execute supplies the taken/not-taken decision.
- Run control: start/halt state machine with a done flag.

Parameters:
- PC_W, 10, program counter and target-table entry width.
- RESET_PC, 0, PC value loaded on reset and on start.
- HALT_OP, 9'h1FF, instruction encoding that stops fetch.

Ports:
- clk  in  1  single clock, rising edge.
- rst_n  in  1  synchronous, active-low reset.
- start  in  1  one-cycle pulse; begins fetch at RESET_PC.
- stall  in  1  freezes PC, instr and instr_valid.
- br_taken  in  1  execute resolved the instruction currently in instr as taken.
- br_idx  in  4  target-table index (decoder imm[3:0] of the branch in instr).
- lut_we  in  1  target-table write enable.
- lut_idx  in  4  target-table write index.
- lut_wdata  in  PC_W  target-table write data.
- imem_addr  out  PC_W  instruction memory address (combinational read).
- imem_rdata  in  9  instruction word at imem_addr, same cycle.
- instr  out  9  registered instruction to decoder.
- instr_valid  out  1  instr is a live instruction.
- pc  out  PC_W  current PC.
- done  out  1  program halted.
- br_count  out  16  taken-branch count (see Optional Feature).

Behaviour:
- Reset (rst_n=0 at clk edge), overriding everything:
  - state=IDLE, pc=RESET_PC, instr=0, instr_valid=0, done=0, br_count=0.
  - All 16 table entries cleared to 0.
- imem_addr = pc at all times.
- States: IDLE, RUN, HALT.
- IDLE:
  - pc held, instr_valid=0.
  - start → RUN; pc=RESET_PC.
- RUN, each edge with stall=0:
  - instr <= imem_rdata.
  - pc <= br_taken ? lut[br_idx] : pc+1.
  - pc+1 wraps modulo 2^PC_W.
- Branch squash:
  - br_taken=1 means the word captured this cycle is the wrong-path fall-through.
  - Next cycle instr_valid=0 (one bubble); otherwise instr_valid=1.
  - Branch penalty is exactly 1 cycle.
- RUN with stall=1:
  - pc, instr, instr_valid hold.
  - br_taken and br_idx ignored; execute must re-present them after the stall.
- Halt:
  - Triggered when a non-squashed capture has imem_rdata==HALT_OP: instr=HALT_OP, instr_valid=1 for that cycle, then state → HALT.
  - In HALT: pc frozen, instr_valid=0, done=1.
  - A halt word captured under br_taken is squashed and does not halt.
- HALT + start → RUN: pc=RESET_PC, done=0 on the next edge.
- start while in RUN: restart, pc=RESET_PC, instr_valid=0 next cycle.
- Target table:
  - Writable in any state.
  - Write and read of the same index in one cycle returns the old entry.
  - Write takes effect next edge.
- Reset mid-RUN or mid-stall: immediate return to IDLE with reset values; in-flight branch discarded.
- Latency: imem word visible on instr one cycle after its address is on imem_addr.

Optional Feature:
- Macro: INSTR_FETCH_BR_COUNT_EN.
- Defined:
  - br_count increments on each accepted taken branch (br_taken=1, stall=0, state RUN).
  - Saturates at 16'hFFFF.
  - Cleared by reset and by start.
- Undefined: no counter logic; br_count tied to 0.

Test Plan:
- Reset, then start with imem holding 9'h010, 9'h011, 9'h012 at 0..2 → instr 010, 011, 012 on consecutive cycles, instr_valid=1, pc 1, 2, 3.
- lut[5]=10'h040 written; br_taken=1, br_idx=5 while instr is at pc 3 → next cycle instr_valid=0 and pc=0x040; following cycle instr=imem[0x040], valid=1; br_count=1 if enabled.
- stall=1 for 3 cycles mid-RUN with br_taken=1 asserted → pc, instr, instr_valid unchanged, no redirect; stall released → normal fetch resumes.
- HALT_OP at addr 4 → instr=1FF valid one cycle, then done=1, pc frozen; start → pc=0, done=0, fetch resumes.
- HALT_OP at the fall-through slot of a taken branch → squashed, done stays 0.
- pc at 10'h3FF, no branch → pc wraps to 0; rst_n=0 mid-RUN → IDLE, lut entries and br_count read 0.
